// File: rtl/key_debouncer_if.sv
// Key debouncer bundle: raw pins in, debounced level and strobes out.
interface key_debouncer_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] rise;
    logic [N_KEYS-1:0] fall;

    modport master (
        output key_raw,
        input  level,
        input  rise,
        input  fall
    );

    modport slave (
        input  key_raw,
        output level,
        output rise,
        output fall
    );
endinterface

// File: rtl/key_debouncer.sv
// Per-channel 2-flop synchronizer plus 4-state debounce FSM with
// a stability counter; emits clean levels and one-cycle rise/fall strobes.
module key_debouncer #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input logic      clk,
    input logic      reset,
    key_debouncer_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REL,
        CONF_P,
        PRS,
        CONF_R
    } state_e;

    state_e        state_q [N_KEYS];
    state_e        state_d [N_KEYS];
    logic [CW-1:0] count_q [N_KEYS];
    logic [CW-1:0] count_d [N_KEYS];

    logic [N_KEYS-1:0] p;
    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] s;
    logic [N_KEYS-1:0] level_q, level_d;
    logic [N_KEYS-1:0] rise_q, rise_d;
    logic [N_KEYS-1:0] fall_q, fall_d;

    // Normalise to pressed-high before the first flop
    assign p = ACTIVE_LOW ? ~bus.key_raw : bus.key_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= p;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= REL;
                count_q[i] <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            unique case (state_q[i])
                REL: begin
                    if (s[i]) begin
                        state_d[i] = CONF_P;
                        count_d[i] = CW'(1);
                    end
                end
                CONF_P: begin
                    if (!s[i]) begin
                        state_d[i] = REL;
                        count_d[i] = '0;
                    end else if (count_q[i] == LAST) begin
                        state_d[i] = PRS;
                        count_d[i] = '0;
                        level_d[i] = 1'b1;
                        rise_d[i]  = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] + CW'(1);
                    end
                end
                PRS: begin
                    if (!s[i]) begin
                        state_d[i] = CONF_R;
                        count_d[i] = CW'(1);
                    end
                end
                CONF_R: begin
                    if (s[i]) begin
                        state_d[i] = PRS;
                        count_d[i] = '0;
                    end else if (count_q[i] == LAST) begin
                        state_d[i] = REL;
                        count_d[i] = '0;
                        level_d[i] = 1'b0;
                        fall_d[i]  = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = REL;
                    count_d[i] = '0;
                end
            endcase
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: 2 channels, D=4, active-low keys.
module tb_key_debouncer;
    logic clk = 1'b0;
    logic reset;

    key_debouncer_if #(.N_KEYS(2)) bus ();

    key_debouncer #(
        .N_KEYS(2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] rise_seen;
    logic [1:0] fall_seen;
    logic       both_seen = 1'b0;
    int         rise0_cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr();
        rise_seen = '0;
        fall_seen = '0;
        rise0_cnt = 0;
    endtask

    // Samples 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        rise_seen = rise_seen | bus.rise;
        fall_seen = fall_seen | bus.fall;
        if (bus.rise[0]) rise0_cnt++;
        if (|(bus.rise & bus.fall)) both_seen = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        bus.key_raw = 2'b11;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_level", 32'(bus.level), 32'h0);
        chk("rst_rise", 32'(bus.rise), 32'h0);
        chk("rst_fall", 32'(bus.fall), 32'h0);
        reset = 1'b0;
        repeat (3) tick();

        // Clean press on channel 0
        clr();
        bus.key_raw = 2'b10;
        repeat (5) tick();
        chk("press_e4_level", 32'(bus.level), 32'h0);
        tick();
        chk("press_e5_level", 32'(bus.level), 32'h1);
        chk("press_e5_rise", 32'(bus.rise), 32'h1);
        tick();
        chk("press_e6_rise", 32'(bus.rise), 32'h0);
        chk("press_e6_level", 32'(bus.level), 32'h1);
        repeat (4) tick();
        chk("press_ch1_quiet",
            32'({rise_seen[1], fall_seen[1], bus.level[1]}), 32'h0);

        // Clean release
        clr();
        bus.key_raw = 2'b11;
        repeat (5) tick();
        chk("rel_e4_level", 32'(bus.level), 32'h1);
        chk("rel_e4_fall", 32'(bus.fall), 32'h0);
        tick();
        chk("rel_e5_fall", 32'(bus.fall), 32'h1);
        chk("rel_e5_level", 32'(bus.level), 32'h0);
        tick();
        chk("rel_e6_fall", 32'(bus.fall), 32'h0);

        // Release with a 2-sample bounce mid-confirm
        bus.key_raw = 2'b10;
        repeat (8) tick();
        chk("relb_pressed", 32'(bus.level), 32'h1);
        clr();
        bus.key_raw = 2'b11;
        repeat (2) tick();
        bus.key_raw = 2'b10;
        repeat (2) tick();
        bus.key_raw = 2'b11;
        repeat (5) tick();
        chk("relb_no_fall", 32'(fall_seen), 32'h0);
        chk("relb_e8_level", 32'(bus.level), 32'h1);
        tick();
        chk("relb_e9_fall", 32'(bus.fall), 32'h1);
        chk("relb_e9_level", 32'(bus.level), 32'h0);

        // Press bounce: 3 low, 1 high, 3 low
        repeat (4) tick();
        clr();
        bus.key_raw = 2'b10;
        repeat (3) tick();
        bus.key_raw = 2'b11;
        tick();
        bus.key_raw = 2'b10;
        repeat (3) tick();
        bus.key_raw = 2'b11;
        repeat (10) tick();
        chk("bounce_no_rise", 32'(rise_seen), 32'h0);
        chk("bounce_level", 32'(bus.level), 32'h0);

        // Independent channels, staggered press, joint release
        clr();
        bus.key_raw = 2'b10;
        repeat (2) tick();
        bus.key_raw = 2'b00;
        repeat (4) tick();
        chk("ind_e5_rise", 32'(bus.rise), 32'h1);
        tick();
        chk("ind_e6_rise", 32'(bus.rise), 32'h0);
        tick();
        chk("ind_e7_rise", 32'(bus.rise), 32'h2);
        repeat (6) tick();
        chk("ind_both_level", 32'(bus.level), 32'h3);
        bus.key_raw = 2'b11;
        repeat (6) tick();
        chk("ind_fall_both", 32'(bus.fall), 32'h3);
        chk("ind_rel_level", 32'(bus.level), 32'h0);

        // Async reset while pressed
        bus.key_raw = 2'b10;
        repeat (8) tick();
        chk("arst_pre_level", 32'(bus.level), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_level", 32'(bus.level), 32'h0);
        chk("arst_rise", 32'(bus.rise), 32'h0);
        chk("arst_fall", 32'(bus.fall), 32'h0);
        bus.key_raw = 2'b11;
        tick();
        reset = 1'b0;
        clr();
        repeat (8) tick();
        chk("arst_after_level", 32'(bus.level), 32'h0);
        chk("arst_after_strobes", 32'({rise_seen, fall_seen}), 32'h0);

        // Held across reset deassertion
        bus.key_raw = 2'b10;
        reset = 1'b1;
        repeat (2) tick();
        clr();
        reset = 1'b0;
        repeat (5) tick();
        chk("held_e4_rise", 32'(bus.rise), 32'h0);
        chk("held_e4_level", 32'(bus.level), 32'h0);
        tick();
        chk("held_e5_rise", 32'(bus.rise), 32'h1);
        chk("held_e5_level", 32'(bus.level), 32'h1);
        repeat (8) tick();
        chk("held_rise_count", 32'(rise0_cnt), 32'h1);
        chk("held_level", 32'(bus.level), 32'h1);

        chk("never_rise_and_fall", 32'(both_seen), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Multi-channel synchronizer and debouncer for the DE1-SoC push-buttons.
- Sits directly upstream of the single-pulse press detector stage.
- Takes raw, asynchronous, bouncing KEY inputs and produces clean, clock-synchronous, active-high levels. It also produces its own one-cycle rise and fall strobes.
- Each channel is independent: 2-flop synchronizer, then a 4-state debounce FSM with a stability counter.

Parameters:
- N_KEYS, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, consecutive identical synchronized samples required to accept a level change (10 ms at 50 MHz); must be >= 2.
- ACTIVE_LOW, 1, 1 = raw input is pressed-when-0 and is inverted before the synchronizer; 0 = raw used as-is.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- key_raw  input  N_KEYS  raw button pins, asynchronous to clk.
- level  output  N_KEYS  debounced pressed state, 1 = pressed.
- rise  output  N_KEYS  one-cycle strobe on debounced press.
- fall  output  N_KEYS  one-cycle strobe on debounced release.

Behaviour:
- Reset is asynchronous and active-high:
  - on assertion, immediately and without waiting for clk: sync flops = 0 (released), state = REL, count = 0, level = 0, rise = 0, fall = 0;
  - reset mid-confirmation discards the partial count.
- Polarity: p = ACTIVE_LOW ? ~key_raw : key_raw, combinational, before the first sync flop.
- Synchronizer: sync1 <= p; s <= sync1. The FSM only ever sees s.
- Counter: per channel, width $clog2(DEBOUNCE_CYCLES+1), saturation never reached.
- States per channel (D = DEBOUNCE_CYCLES):
  - REL: if s=1 -> CONF_P, count=1; else stay.
  - CONF_P: if s=0 -> REL, count=0 (bounce rejected, no strobe); else if count==D-1 -> PRS, level<=1, rise<=1; else count++.
  - PRS: if s=0 -> CONF_R, count=1; else stay.
  - CONF_R: if s=1 -> PRS, count=0 (no strobe); else if count==D-1 -> REL, level<=0, fall<=1; else count++.
- Acceptance: a change is accepted after exactly D consecutive equal samples of s.
- Latency: raw change first captured by sync1 at edge E0 -> level changes and strobe asserts after edge E(D+1), i.e. D+2 clocks. With D=4 that is 6 clocks.
- rise and fall:
  - registered; high for exactly one cycle, coincident with the first cycle of the new level value;
  - never both high on one channel;
  - cleared to 0 on every other edge.
- Back-to-back: minimum spacing between rise and the next fall on a channel is D cycles after level change.
- Channels never interact; simultaneous events on different channels are each handled independently in the same cycle.
- Button held across reset deassertion: treated as a fresh press; rise occurs D+2 cycles after the first post-reset edge.
- Glitches shorter than D samples produce no output change.
- Metastability is confined to sync1.

Test Plan:
(Bench parameters: N_KEYS=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, key_raw idle = 2'b11.)
1. Async reset: drive key_raw[0]=0 until level[0]=1, then assert reset between clock edges -> level/rise/fall = 0 before the next posedge; state resumes REL after deassert.
2. Clean press: key_raw[0] 1->0 sampled at E0 and held 10 cycles -> level[0]=1 and rise[0]=1 after E5, rise[0]=0 after E6; level[1], rise[1], fall[1] stay 0 throughout.
3. Bounce rejection: key_raw[0] low 3 cycles, high 1, low 3, high -> level[0] stays 0, rise[0] never asserts.
4. Release: from pressed, key_raw[0] 0->1 held -> fall[0]=1 for one cycle and level[0]=0 six cycles after first sampling; release bounce of 2 cycles low mid-confirm restarts the count, with no fall until 4 clean samples.
5. Independent channels: key_raw[0] pressed at E0, key_raw[1] pressed at E2 -> rise[0] after E5, rise[1] after E7; both released on the same cycle -> fall[0] and fall[1] asserted in the same cycle.
6. Held through reset: key_raw[0]=0 during and after reset deassert -> exactly one rise[0] pulse, after E5 relative to the first post-reset edge.
